// File: rtl/reg_seq_ctrl_if.sv
// Bus bundle between reg_seq_ctrl and its neighbours: the instruction memory
// fetch handshake, the 32x8 register-file ports and the external ALU.
// master = sequencer side, slave = memory / register file / ALU side.
interface reg_seq_ctrl_if;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;

  logic [7:0] A1;
  logic [7:0] A2;
  logic [7:0] A3;
  logic [7:0] WriteData;
  logic [6:0] Flag_input;
  logic       regReadEnable;
  logic       regWriteEnable;

  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic [6:0] alu_flags;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    output A1, A2, A3, WriteData, Flag_input, regReadEnable, regWriteEnable,
    output alu_op,
    input  alu_result, alu_flags
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    input  A1, A2, A3, WriteData, Flag_input, regReadEnable, regWriteEnable,
    input  alu_op,
    output alu_result, alu_flags
  );
endinterface

// File: rtl/reg_seq_ctrl.sv
// Instruction fetch/decode/sequencing controller in front of the 32x8
// register file. Fetches 3-byte instructions over imem_req/imem_ack, drives
// the register-file read/write ports and the ALU opcode, and writes back the
// latched ALU result and flags. Register FLAG_REG is never a legal rd.
//
// Optional feature: define REG_SEQ_SINGLE_STEP_EN to add the step input and
// the PAUSE state (one instruction per step after each retire).
//
// state | meaning
// ------+-----------------------------------------------------------
// F0    | fetch opcode byte {op,rd}; first cycle after reset raises req
// F1    | fetch rs1 byte
// F2    | fetch rs2 / imm8 byte
// DEC   | decode; NOP/JMP/illegal retire here, HLT parks
// EXEC  | register read + ALU, result/flags latched at the edge
// WB    | single-cycle register-file write, retire pulse
// HALT  | parked until reset
// PAUSE | waiting for step (single-step builds only)
module reg_seq_ctrl #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [4:0] FLAG_REG = 5'd3
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef REG_SEQ_SINGLE_STEP_EN
  input  logic          step,
`endif
  reg_seq_ctrl_if.master bus,
  output logic          instr_retired,
  output logic          halted,
  output logic          illegal
);

`ifdef REG_SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {F0, F1, F2, DEC, EXEC, WB, HALT, PAUSE} state_t;
  localparam state_t RETIRE_ST  = PAUSE;
  localparam logic   RETIRE_REQ = 1'b0;
`else
  typedef enum logic [2:0] {F0, F1, F2, DEC, EXEC, WB, HALT} state_t;
  localparam state_t RETIRE_ST  = F0;
  localparam logic   RETIRE_REQ = 1'b1;
`endif

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  state_t     state;
  logic [7:0] pc;
  logic [2:0] op;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [7:0] b2;

  logic       req_q;
  logic [7:0] a1_q, a2_q, a3_q, wd_q;
  logic [6:0] flags_q;
  logic       re_q, we_q;
  logic [1:0] alu_op_q;

  // pc is the fetch address; it only moves on an accepted byte or a JMP
  assign bus.imem_addr      = pc;
  assign bus.imem_req       = req_q;
  assign bus.A1             = a1_q;
  assign bus.A2             = a2_q;
  assign bus.A3             = a3_q;
  assign bus.WriteData      = wd_q;
  assign bus.Flag_input     = flags_q;
  assign bus.regReadEnable  = re_q;
  assign bus.regWriteEnable = we_q;
  assign bus.alu_op         = alu_op_q;

  logic fetch_ok;
  logic dest_bad;
  assign fetch_ok = req_q & bus.imem_ack;
  assign dest_bad = (rd == FLAG_REG);

  // Sequencer: state, pc, instruction latches and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= F0;
      pc            <= PC_RESET;
      op            <= 3'd0;
      rd            <= 5'd0;
      rs1           <= 5'd0;
      b2            <= 8'd0;
      req_q         <= 1'b0;
      a1_q          <= 8'd0;
      a2_q          <= 8'd0;
      a3_q          <= 8'd0;
      wd_q          <= 8'd0;
      flags_q       <= 7'd0;
      re_q          <= 1'b0;
      we_q          <= 1'b0;
      alu_op_q      <= 2'd0;
      instr_retired <= 1'b0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      instr_retired <= 1'b0;
      case (state)
        F0: begin
          // req is low only on the first cycle out of reset
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (fetch_ok) begin
            op    <= bus.imem_data[7:5];
            rd    <= bus.imem_data[4:0];
            pc    <= pc + 8'd1;
            state <= F1;
          end
        end
        F1: begin
          if (fetch_ok) begin
            rs1   <= bus.imem_data[4:0];
            pc    <= pc + 8'd1;
            state <= F2;
          end
        end
        F2: begin
          if (fetch_ok) begin
            b2    <= bus.imem_data;
            pc    <= pc + 8'd1;
            req_q <= 1'b0;
            state <= DEC;
          end
        end
        DEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              if (dest_bad) begin
                illegal       <= 1'b1;
                instr_retired <= 1'b1;
                req_q         <= RETIRE_REQ;
                state         <= RETIRE_ST;
              end else begin
                a1_q     <= {3'b000, rs1};
                a2_q     <= {3'b000, b2[4:0]};
                alu_op_q <= 2'(op - 3'd1);
                re_q     <= 1'b1;
                state    <= EXEC;
              end
            end
            OP_LDI: begin
              if (dest_bad) begin
                illegal       <= 1'b1;
                instr_retired <= 1'b1;
                req_q         <= RETIRE_REQ;
                state         <= RETIRE_ST;
              end else begin
                // flags_q is left alone so the previous ALU flags are rewritten
                a3_q          <= {3'b000, rd};
                wd_q          <= b2;
                we_q          <= 1'b1;
                instr_retired <= 1'b1;
                state         <= WB;
              end
            end
            OP_JMP: begin
              pc            <= b2;
              instr_retired <= 1'b1;
              req_q         <= RETIRE_REQ;
              state         <= RETIRE_ST;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: begin
              instr_retired <= 1'b1;
              req_q         <= RETIRE_REQ;
              state         <= RETIRE_ST;
            end
          endcase
        end
        EXEC: begin
          wd_q          <= bus.alu_result;
          flags_q       <= bus.alu_flags;
          re_q          <= 1'b0;
          a1_q          <= 8'd0;
          a2_q          <= 8'd0;
          alu_op_q      <= 2'd0;
          a3_q          <= {3'b000, rd};
          we_q          <= 1'b1;
          instr_retired <= 1'b1;
          state         <= WB;
        end
        WB: begin
          we_q  <= 1'b0;
          a3_q  <= 8'd0;
          req_q <= RETIRE_REQ;
          state <= RETIRE_ST;
        end
        HALT: begin
          halted <= 1'b1;
        end
`ifdef REG_SEQ_SINGLE_STEP_EN
        PAUSE: begin
          if (step) begin
            req_q <= 1'b1;
            state <= F0;
          end
        end
`endif
        default: begin
          req_q <= 1'b0;
          state <= F0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed bench for reg_seq_ctrl: instruction memory responder with a
// programmable ack delay, constant ALU stimulus, hand-computed expectations.
// Cycle 1 of an instruction is the first cycle imem_req is high for it.
module tb_reg_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_retired, halted, illegal;
`ifdef REG_SEQ_SINGLE_STEP_EN
  logic step = 1'b0;
`endif

  reg_seq_ctrl_if bus ();

  reg_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef REG_SEQ_SINGLE_STEP_EN
    .step         (step),
`endif
    .bus          (bus),
    .instr_retired(instr_retired),
    .halted       (halted),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [256];
  int ack_delay = 0;
  int wcnt = 0;

  // Memory responder: ack after ack_delay wait cycles per byte
  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.imem_req) begin
        if (wcnt >= ack_delay) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = mem[bus.imem_addr];
          wcnt = 0;
        end else begin
          bus.imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", bus.imem_addr); end
    checks++; if ({bus.regReadEnable, bus.regWriteEnable, instr_retired, halted, illegal} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {bus.regReadEnable, bus.regWriteEnable, instr_retired, halted, illegal}); end
    checks++; if ({bus.A1, bus.A2, bus.A3, bus.WriteData, bus.Flag_input, bus.alu_op} !== 41'd0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {bus.A1, bus.A2, bus.A3, bus.WriteData, bus.Flag_input, bus.alu_op}); end
  endtask

  task automatic test_add();
    bit ok;
    int we_cnt = 0, we_cyc = 0, re_cyc = 0, both = 0;
    logic [7:0] a1 = 0, a2 = 0, a3 = 0, wd = 0, pcw = 0;
    logic [6:0] fl = 0;
    logic [1:0] aop = 2'b11;
    logic ret = 0;
    clear_mem();
    mem[0] = 8'h21; mem[1] = 8'h01; mem[2] = 8'h02;
    ack_delay = 0;
    bus.alu_result = 8'h5A; bus.alu_flags = 7'h01;
    do_reset();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_req_timeout: got no req want req"); end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (bus.regWriteEnable) begin
        we_cnt++; we_cyc = cyc; a3 = bus.A3; wd = bus.WriteData; fl = bus.Flag_input;
        pcw = bus.imem_addr; ret = instr_retired;
      end
      if (bus.regReadEnable) begin re_cyc = cyc; a1 = bus.A1; a2 = bus.A2; aop = bus.alu_op; end
      if (bus.regReadEnable && bus.regWriteEnable) both = 1;
      @(negedge clk);
    end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL add_we_count: got %0d want 1", we_cnt); end
    checks++; if (we_cyc !== 6) begin errors++; $display("FAIL add_we_cycle: got %0d want 6", we_cyc); end
    checks++; if (re_cyc !== 5) begin errors++; $display("FAIL add_re_cycle: got %0d want 5", re_cyc); end
    checks++; if ({a1, a2} !== 16'h0102) begin errors++; $display("FAIL add_a1a2: got %h want 0102", {a1, a2}); end
    checks++; if (aop !== 2'b00) begin errors++; $display("FAIL add_alu_op: got %b want 00", aop); end
    checks++; if (a3 !== 8'h01) begin errors++; $display("FAIL add_a3: got %h want 01", a3); end
    checks++; if (wd !== 8'h5A) begin errors++; $display("FAIL add_wdata: got %h want 5a", wd); end
    checks++; if (fl !== 7'h01) begin errors++; $display("FAIL add_flags: got %h want 01", fl); end
    checks++; if (pcw !== 8'h03) begin errors++; $display("FAIL add_pc: got %h want 03", pcw); end
    checks++; if (ret !== 1'b1) begin errors++; $display("FAIL add_retire: got %b want 1", ret); end
    checks++; if (both !== 0) begin errors++; $display("FAIL add_re_we_overlap: got %0d want 0", both); end
  endtask

  task automatic test_ldi();
    bit ok;
    int we_cnt = 0, we_cyc = 0, re_cnt = 0;
    logic [7:0] a3 = 0, wd = 0;
    logic [6:0] fl = 7'h7F;
    clear_mem();
    mem[0] = 8'hA4; mem[1] = 8'h00; mem[2] = 8'hC3;
    ack_delay = 2;
    bus.alu_result = 8'h77; bus.alu_flags = 7'h55;
    do_reset();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ldi_req_timeout: got no req want req"); end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (bus.regWriteEnable) begin we_cnt++; we_cyc = cyc; a3 = bus.A3; wd = bus.WriteData; fl = bus.Flag_input; end
      if (bus.regReadEnable) re_cnt++;
      @(negedge clk);
    end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL ldi_we_count: got %0d want 1", we_cnt); end
    checks++; if (we_cyc !== 11) begin errors++; $display("FAIL ldi_we_cycle: got %0d want 11", we_cyc); end
    checks++; if (wd !== 8'hC3) begin errors++; $display("FAIL ldi_wdata: got %h want c3", wd); end
    checks++; if (a3 !== 8'h04) begin errors++; $display("FAIL ldi_a3: got %h want 04", a3); end
    checks++; if (fl !== 7'h00) begin errors++; $display("FAIL ldi_flags: got %h want 00", fl); end
    checks++; if (re_cnt !== 0) begin errors++; $display("FAIL ldi_no_read: got %0d want 0", re_cnt); end
  endtask

  task automatic test_jmp();
    logic [7:0] exp_addr [7] = '{8'h00, 8'h01, 8'h02, 8'hFD, 8'hFE, 8'hFF, 8'h10};
    logic [7:0] got_addr [7];
    int n = 0, we_cnt = 0;
    bit got_pc = 0;
    logic [7:0] pc_dec = 8'hAA;
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h00; mem[2] = 8'hFD;
    mem[8'hFD] = 8'hC0; mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h10;
    ack_delay = 0;
    for (int i = 0; i < 7; i++) got_addr[i] = 8'h55;
    do_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_ack) begin
        if (n < 7) got_addr[n] = bus.imem_addr;
        n++;
      end else if (n == 6 && !got_pc) begin
        got_pc = 1; pc_dec = bus.imem_addr;
      end
      if (bus.regWriteEnable) we_cnt++;
    end
    for (int i = 0; i < 7; i++) begin
      checks++; if (got_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL jmp_fetch_addr[%0d]: got %h want %h", i, got_addr[i], exp_addr[i]); end
    end
    checks++; if (pc_dec !== 8'h00) begin errors++; $display("FAIL jmp_pc_wrap: got %h want 00", pc_dec); end
    checks++; if (n !== 9) begin errors++; $display("FAIL jmp_fetch_count: got %0d want 9", n); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL jmp_no_write: got %0d want 0", we_cnt); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL jmp_halted: got %b want 1", halted); end
  endtask

  task automatic test_illegal();
    int n = 0, we_cnt = 0, re_cnt = 0, ret_cnt = 0;
    logic [7:0] fourth = 8'hAA;
    clear_mem();
    mem[0] = 8'h23; mem[1] = 8'h01; mem[2] = 8'h02;
    ack_delay = 0;
    bus.alu_result = 8'h99; bus.alu_flags = 7'h7F;
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_ack) begin
        if (n == 3) fourth = bus.imem_addr;
        n++;
      end
      if (bus.regWriteEnable) we_cnt++;
      if (bus.regReadEnable) re_cnt++;
      if (instr_retired) ret_cnt++;
    end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", illegal); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL illegal_no_write: got %0d want 0", we_cnt); end
    checks++; if (re_cnt !== 0) begin errors++; $display("FAIL illegal_no_read: got %0d want 0", re_cnt); end
    checks++; if (ret_cnt !== 1) begin errors++; $display("FAIL illegal_retire: got %0d want 1", ret_cnt); end
    checks++; if (fourth !== 8'h03) begin errors++; $display("FAIL illegal_next_fetch: got %h want 03", fourth); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL illegal_then_halt: got %b want 1", halted); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a3 [4] = '{8'h01, 8'h02, 8'h05, 8'h06};
    logic [7:0] exp_a1 [4] = '{8'h01, 8'h05, 8'h07, 8'h09};
    int exp_cyc [4] = '{6, 12, 18, 24};
    logic [7:0] got_a3 [4], got_a1 [4];
    logic [1:0] got_op [4];
    int got_cyc [4];
    int we_n = 0, re_n = 0, ret_cnt = 0;
    bit ok;
    clear_mem();
    mem[0] = 8'h21; mem[1]  = 8'h01; mem[2]  = 8'h02;
    mem[3] = 8'h42; mem[4]  = 8'h05; mem[5]  = 8'h06;
    mem[6] = 8'h65; mem[7]  = 8'h07; mem[8]  = 8'h08;
    mem[9] = 8'h86; mem[10] = 8'h09; mem[11] = 8'h0A;
    ack_delay = 0;
    bus.alu_result = 8'h33; bus.alu_flags = 7'h12;
    for (int i = 0; i < 4; i++) begin got_a3[i] = 0; got_a1[i] = 0; got_op[i] = 0; got_cyc[i] = 0; end
    do_reset();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_req_timeout: got no req want req"); end
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (bus.regWriteEnable) begin
        if (we_n < 4) begin got_a3[we_n] = bus.A3; got_cyc[we_n] = cyc; end
        we_n++;
      end
      if (bus.regReadEnable) begin
        if (re_n < 4) begin got_a1[re_n] = bus.A1; got_op[re_n] = bus.alu_op; end
        re_n++;
      end
      if (instr_retired) ret_cnt++;
      @(negedge clk);
    end
    checks++; if (we_n !== 4) begin errors++; $display("FAIL b2b_we_count: got %0d want 4", we_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL b2b_we_cycle[%0d]: got %0d want %0d", i, got_cyc[i], exp_cyc[i]); end
      checks++; if (got_a3[i] !== exp_a3[i]) begin errors++; $display("FAIL b2b_a3[%0d]: got %h want %h", i, got_a3[i], exp_a3[i]); end
      checks++; if (got_a1[i] !== exp_a1[i]) begin errors++; $display("FAIL b2b_a1[%0d]: got %h want %h", i, got_a1[i], exp_a1[i]); end
      checks++; if (got_op[i] !== 2'(i)) begin errors++; $display("FAIL b2b_alu_op[%0d]: got %b want %0d", i, got_op[i], i); end
    end
    checks++; if (ret_cnt !== 4) begin errors++; $display("FAIL b2b_retire_count: got %0d want 4", ret_cnt); end
  endtask

  task automatic test_halt_reset();
    int req_hi = 0;
    bit hit = 0, acked = 0;
    clear_mem();
    ack_delay = 0;
    do_reset();
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_clears_illegal: got %b want 0", illegal); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) begin hit = 1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL halt_timeout: got no halt want halt"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req || !halted) req_hi++;
    end
    checks++; if (req_hi !== 0) begin errors++; $display("FAIL halt_quiet: got %0d bad cycles want 0", req_hi); end
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00;
    ack_delay = 3;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_ack) begin acked = 1; break; end
    end
    checks++; if (!acked) begin errors++; $display("FAIL f0_ack_timeout: got no ack want ack"); end
    @(negedge clk);
    checks++; if ({bus.imem_req, bus.imem_addr} !== 9'h101) begin errors++; $display("FAIL mid_f1: got %h want 101", {bus.imem_req, bus.imem_addr}); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_drops_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h want 00", bus.imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef REG_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    int ret_cnt = 0;
    clear_mem();
    for (int i = 0; i < 6; i++) mem[i] = 8'h00;
    ack_delay = 0;
    step = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (instr_retired) ret_cnt++;
    end
    checks++; if (ret_cnt !== 1) begin errors++; $display("FAIL step_first_retire: got %0d want 1", ret_cnt); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL step_paused: got %b want 0", bus.imem_req); end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (instr_retired) ret_cnt++;
    end
    checks++; if (ret_cnt !== 2) begin errors++; $display("FAIL step_one_more: got %0d want 2", ret_cnt); end
    checks++; if (bus.imem_addr !== 8'h06) begin errors++; $display("FAIL step_pc: got %h want 06", bus.imem_addr); end
  endtask
`endif

  initial begin
    bus.alu_result = 8'h00;
    bus.alu_flags  = 7'h00;
    clear_mem();
    test_reset();
    test_add();
    test_ldi();
    test_jmp();
    test_illegal();
    test_back_to_back();
    test_halt_reset();
`ifdef REG_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
